// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous icache read port,
// holds the fetched word across stalls and squashes the slot in which a redirect lands.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        icache_re,
  output logic [31:0] icache_addr,
  input  logic [31:0] icache_dout,
  output logic [31:0] d_inst,
  output logic [31:0] d_pc,
  output logic        d_valid
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] redir_tgt;
  logic [31:0] next_pc;
  logic        apply_redirect;

  always_comb begin
    redir_tgt      = redirect_pc & ~32'h0000_0003;
    apply_redirect = (state_q != BOOT) && !stall && (redirect_valid || pend_valid_q);

    if (state_q == BOOT)               next_pc = RESET_PC;
    else if (redirect_valid && !stall) next_pc = redir_tgt;
    else if (pend_valid_q && !stall)   next_pc = pend_pc_q;
    else if (stall)                    next_pc = pc_q;
    else                               next_pc = pc_q + 32'd4;

    pc_d = stall ? pc_q : next_pc;

    // Newest redirect seen during a stall wins; any unstalled cycle either applies or has nothing queued.
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    if (state_q != BOOT) begin
      if (stall && redirect_valid) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = redir_tgt;
      end else if (!stall) begin
        pend_valid_d = 1'b0;
      end
    end

    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      BOOT: if (!stall) state_d = RUN;
      RUN: begin
        if (stall) begin
          hold_d  = icache_dout;
          state_d = HOLD;
        end
      end
      HOLD:    if (!stall) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    d_inst  = NOP_INST;
    d_pc    = RESET_PC;
    d_valid = 1'b0;
    case (state_q)
      RUN: begin
        d_inst  = icache_dout;
        d_pc    = pc_q;
        d_valid = 1'b1;
      end
      HOLD: begin
        d_inst  = hold_q;
        d_pc    = pc_q;
        d_valid = 1'b1;
      end
      default: ;
    endcase
    if (apply_redirect) begin
      d_inst  = NOP_INST;
      d_valid = 1'b0;
    end
  end

  assign icache_re   = reset_n && !stall;
  assign icache_addr = next_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      hold_q       <= NOP_INST;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

endmodule
